// File: rtl/dcpu16_mbus.sv
// Memory bus arbiter for the DCPU16 core: shares one external bus between fetch and data ports.
// Optional watchdog enabled by defining DCPU16_MBUS_TMO_EN.
module dcpu16_mbus #(
  parameter int unsigned AW  = 16,
  parameter int unsigned DW  = 16,
  parameter int unsigned TMO = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] f_adr,
  input  logic          f_stb,
  output logic [DW-1:0] f_dti,
  output logic          f_ack,
  input  logic [AW-1:0] g_adr,
  input  logic          g_stb,
  input  logic          g_wre,
  input  logic [DW-1:0] g_dto,
  output logic [DW-1:0] g_dti,
  output logic          g_ack,
  output logic [AW-1:0] w_adr,
  output logic          w_stb,
  output logic          w_wre,
  output logic [DW-1:0] w_dto,
  input  logic [DW-1:0] w_dti,
  input  logic          w_ack,
  output logic          ena,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FGNT = 2'd1,
    GGNT = 2'd2,
    TURN = 2'd3
  } state_t;

  state_t        state;
  logic          last_g;
  logic          in_gnt;
  logic          pick_f;
  logic          pick_g;
  logic          tmo_hit;
  logic          done;
  logic [DW-1:0] rd_data;

  // Round-robin: on a tie the port that did not win last time is granted.
  assign in_gnt = (state == FGNT) || (state == GGNT);
  assign pick_f = f_stb & (~g_stb | last_g);
  assign pick_g = g_stb & (~f_stb | ~last_g);
  assign done   = in_gnt & (w_ack | tmo_hit);

  assign f_ack = done & (state == FGNT);
  assign g_ack = done & (state == GGNT);
  assign f_dti = rd_data;
  assign g_dti = rd_data;

  // Stall the core while any strobed request has not yet been acknowledged.
  assign ena = ~((f_stb & ~f_ack) | (g_stb & ~g_ack));

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      last_g <= 1'b1;
      w_stb  <= 1'b0;
      w_wre  <= 1'b0;
      w_adr  <= '0;
      w_dto  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_f) begin
            state  <= FGNT;
            last_g <= 1'b0;
            w_stb  <= 1'b1;
            w_adr  <= f_adr;
            w_wre  <= 1'b0;
            w_dto  <= '0;
          end else if (pick_g) begin
            state  <= GGNT;
            last_g <= 1'b1;
            w_stb  <= 1'b1;
            w_adr  <= g_adr;
            w_wre  <= g_wre;
            w_dto  <= g_dto;
          end
        end
        FGNT, GGNT: begin
          if (done) begin
            state <= TURN;
            w_stb <= 1'b0;
          end
        end
        TURN:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DCPU16_MBUS_TMO_EN
  localparam int unsigned CLOG = $clog2(TMO + 1);
  localparam int unsigned CW   = (CLOG < 4) ? 4 : CLOG;

  logic [CW-1:0] tmo_cnt;
  logic          err_q;

  // A grant that sees no w_ack for TMO cycles is completed with all-ones data.
  assign tmo_hit = in_gnt & ~w_ack & (tmo_cnt == CW'(TMO));
  assign rd_data = tmo_hit ? '1 : w_dti;
  assign err     = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (!in_gnt) begin
        tmo_cnt <= '0;
      end else if (!w_ack && !tmo_hit) begin
        tmo_cnt <= tmo_cnt + CW'(1);
      end
      if (tmo_hit) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  logic unused_tmo;

  assign tmo_hit    = 1'b0;
  assign rd_data    = w_dti;
  assign err        = 1'b0;
  assign unused_tmo = ^32'(TMO);
`endif

endmodule

// File: tb/tb_dcpu16_mbus.sv
// Bench for dcpu16_mbus: directed vector table, hand-written corner sequences and a
// randomized run against a transaction-level owner/turnaround model.
module tb_dcpu16_mbus;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] f_adr, g_adr, g_dto, w_dti;
  logic        f_stb, g_stb, g_wre, w_ack;
  logic [15:0] f_dti, g_dti, w_adr, w_dto;
  logic        f_ack, g_ack, w_stb, w_wre, ena, err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dcpu16_mbus dut (
    .clk(clk), .rst(rst),
    .f_adr(f_adr), .f_stb(f_stb), .f_dti(f_dti), .f_ack(f_ack),
    .g_adr(g_adr), .g_stb(g_stb), .g_wre(g_wre), .g_dto(g_dto), .g_dti(g_dti), .g_ack(g_ack),
    .w_adr(w_adr), .w_stb(w_stb), .w_wre(w_wre), .w_dto(w_dto), .w_dti(w_dti), .w_ack(w_ack),
    .ena(ena), .err(err)
  );

  typedef struct {
    logic        fs;
    logic [15:0] fa;
    logic        gs;
    logic        gw;
    logic [15:0] ga;
    logic [15:0] gd;
    logic        wa;
    logic [15:0] wd;
    logic        e_fack;
    logic        e_gack;
    logic        e_ena;
    logic        e_wstb;
    logic [15:0] e_wadr;
    logic        e_wwre;
    logic [15:0] e_wdto;
    logic [15:0] e_dti;
  } vec_t;

  vec_t tbl[$];
  logic [15:0] mem [int];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic fs, input logic [15:0] fa, input logic gs, input logic gw,
                              input logic [15:0] ga, input logic [15:0] gd, input logic wa,
                              input logic [15:0] wd, input logic efa, input logic ega, input logic een,
                              input logic ews, input logic [15:0] ewa, input logic eww,
                              input logic [15:0] ewd, input logic [15:0] edt);
    vec_t v;
    v.fs = fs; v.fa = fa; v.gs = gs; v.gw = gw; v.ga = ga; v.gd = gd; v.wa = wa; v.wd = wd;
    v.e_fack = efa; v.e_gack = ega; v.e_ena = een; v.e_wstb = ews;
    v.e_wadr = ewa; v.e_wwre = eww; v.e_wdto = ewd; v.e_dti = edt;
    return v;
  endfunction

  function automatic logic [15:0] rd(input logic [15:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return a ^ 16'h5A5A;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    f_stb = 1'b0; g_stb = 1'b0; g_wre = 1'b0; w_ack = 1'b0;
    f_adr = '0; g_adr = '0; g_dto = '0; w_dti = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    // fs fa gs gw ga gd wa wd | f_ack g_ack ena w_stb w_adr w_wre w_dto dti
    tbl.push_back(mk(1, 16'h0010, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 16'h0010, 0, 0, 0, 0, 0, 0,            0, 0, 0, 1, 16'h0010, 0, 0, 0));
    tbl.push_back(mk(1, 16'h0010, 0, 0, 0, 0, 0, 0,            0, 0, 0, 1, 16'h0010, 0, 0, 0));
    tbl.push_back(mk(1, 16'h0010, 0, 0, 0, 0, 1, 16'h7C01,     1, 0, 1, 1, 16'h0010, 0, 0, 16'h7C01));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                   0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                   0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 16'h8000, 16'hBEEF, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 16'h8000, 16'hBEEF, 0, 0,     0, 0, 0, 1, 16'h8000, 1, 16'hBEEF, 0));
    tbl.push_back(mk(0, 0, 1, 1, 16'h8000, 16'hBEEF, 1, 16'h5555, 0, 1, 1, 1, 16'h8000, 1, 16'hBEEF, 16'h5555));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                   0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 16'hAAAA,            0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 16'hFFFF, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 16'hFFFF, 0, 0, 0, 0, 0, 0,            0, 0, 0, 1, 16'hFFFF, 0, 16'h0000, 0));
    tbl.push_back(mk(1, 16'hFFFF, 0, 0, 0, 0, 1, 16'h1234,     1, 0, 1, 1, 16'hFFFF, 0, 16'h0000, 16'h1234));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 16'h9999,            0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                   0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 16'h0042, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 16'h0042, 0, 0, 0,            0, 0, 1, 1, 16'h0042, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 0, 0, 0, 16'h0042, 0, 1, 16'h0ABC,     0, 1, 1, 1, 16'h0042, 0, 16'h0000, 16'h0ABC));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                   0, 0, 1, 0, 0, 0, 0, 0));

    do_reset();
    chk("rst_w_stb", 32'(w_stb), 32'd0);
    chk("rst_w_adr", 32'(w_adr), 32'd0);
    chk("rst_w_wre", 32'(w_wre), 32'd0);
    chk("rst_w_dto", 32'(w_dto), 32'd0);
    chk("rst_f_ack", 32'(f_ack), 32'd0);
    chk("rst_g_ack", 32'(g_ack), 32'd0);
    chk("rst_ena",   32'(ena),   32'd1);
    chk("rst_err",   32'(err),   32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      f_stb = tbl[i].fs; f_adr = tbl[i].fa;
      g_stb = tbl[i].gs; g_wre = tbl[i].gw; g_adr = tbl[i].ga; g_dto = tbl[i].gd;
      w_ack = tbl[i].wa; w_dti = tbl[i].wd;
      #1;
      chk($sformatf("vec%0d_f_ack", i), 32'(f_ack), 32'(tbl[i].e_fack));
      chk($sformatf("vec%0d_g_ack", i), 32'(g_ack), 32'(tbl[i].e_gack));
      chk($sformatf("vec%0d_ena", i),   32'(ena),   32'(tbl[i].e_ena));
      chk($sformatf("vec%0d_w_stb", i), 32'(w_stb), 32'(tbl[i].e_wstb));
      if (tbl[i].e_wstb) begin
        chk($sformatf("vec%0d_w_adr", i), 32'(w_adr), 32'(tbl[i].e_wadr));
        chk($sformatf("vec%0d_w_wre", i), 32'(w_wre), 32'(tbl[i].e_wwre));
        chk($sformatf("vec%0d_w_dto", i), 32'(w_dto), 32'(tbl[i].e_wdto));
      end
      if (tbl[i].e_fack) chk($sformatf("vec%0d_f_dti", i), 32'(f_dti), 32'(tbl[i].e_dti));
      if (tbl[i].e_gack) chk($sformatf("vec%0d_g_dti", i), 32'(g_dti), 32'(tbl[i].e_dti));
      @(posedge clk);
      #1;
    end

    // Tie after reset: grants must alternate F,G,F,G.
    begin
      int gcount;
      int who;
      gcount = 0;
      who = 0;
      do_reset();
      f_adr = 16'h1000; g_adr = 16'h2000; g_wre = 1'b0;
      f_stb = 1'b1; g_stb = 1'b1;
      for (int c = 0; c < 40 && gcount < 4; c++) begin
        #1;
        if (w_stb) begin
          who = (w_adr == 16'h1000) ? 0 : 1;
          chk($sformatf("tie_order%0d", gcount), 32'(who), 32'(gcount % 2));
          w_ack = 1'b1; w_dti = 16'h00AA;
          #1;
          chk($sformatf("tie_ack%0d", gcount), 32'(who == 0 ? f_ack : g_ack), 32'd1);
          gcount++;
        end
        @(posedge clk);
        #1;
        if (w_ack) begin
          if (who == 0) f_stb = 1'b0; else g_stb = 1'b0;
        end else begin
          f_stb = 1'b1; g_stb = 1'b1;
        end
        w_ack = 1'b0;
      end
      chk("tie_grants", 32'(gcount), 32'd4);
    end

    // Reset while data owns the bus.
    do_reset();
    g_stb = 1'b1; g_wre = 1'b1; g_adr = 16'h3000; g_dto = 16'h1111;
    @(posedge clk); #1;
    chk("rstmid_w_stb_gnt", 32'(w_stb), 32'd1);
    rst = 1'b1; g_stb = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rstmid_w_stb", 32'(w_stb), 32'd0);
    chk("rstmid_ena", 32'(ena), 32'd1);
    w_ack = 1'b1;
    #1;
    chk("rstmid_g_ack", 32'(g_ack), 32'd0);
    chk("rstmid_f_ack", 32'(f_ack), 32'd0);
    @(posedge clk); #1;
    w_ack = 1'b0;
    chk("rstmid_idle", 32'(w_stb), 32'd0);

    // Randomized traffic against an owner/turnaround transaction model.
    begin
      int owner, gap, lat_t, lat_c;
      logic last_g, f_drop, g_drop, ef, eg, een;
      logic [15:0] t_adr, t_dto;
      logic t_wre;
      do_reset();
      owner = 0; gap = 0; lat_t = 0; lat_c = 0; last_g = 1'b1; f_drop = 1'b0; g_drop = 1'b0;
      t_adr = '0; t_dto = '0; t_wre = 1'b0;
      for (int c = 0; c < 600; c++) begin
        if (f_drop) begin
          f_stb = 1'b0; f_drop = 1'b0;
        end else if (!f_stb && $urandom_range(0, 1) == 1) begin
          f_stb = 1'b1;
          f_adr = ($urandom_range(0, 7) == 7) ? 16'hFFFF : 16'($urandom_range(0, 7));
        end
        if (g_drop) begin
          g_stb = 1'b0; g_drop = 1'b0;
        end else if (!g_stb && $urandom_range(0, 1) == 1) begin
          g_stb = 1'b1;
          g_adr = 16'($urandom_range(0, 7));
          g_wre = 1'($urandom_range(0, 1));
          g_dto = 16'($urandom);
        end
        if (owner != 0) begin
          w_ack = (lat_c == lat_t);
          w_dti = rd(t_adr);
          lat_c++;
        end else begin
          w_ack = ($urandom_range(0, 7) == 0);
          w_dti = 16'($urandom);
        end
        #1;
        ef  = (owner == 1) && w_ack;
        eg  = (owner == 2) && w_ack;
        een = !((f_stb && !ef) || (g_stb && !eg));
        chk("rnd_f_ack", 32'(f_ack), 32'(ef));
        chk("rnd_g_ack", 32'(g_ack), 32'(eg));
        chk("rnd_ena",   32'(ena),   32'(een));
        chk("rnd_w_stb", 32'(w_stb), 32'(owner != 0));
        if (owner != 0) begin
          chk("rnd_w_adr", 32'(w_adr), 32'(t_adr));
          chk("rnd_w_wre", 32'(w_wre), 32'(t_wre));
          chk("rnd_w_dto", 32'(w_dto), 32'(t_dto));
        end
        if (ef) chk("rnd_f_dti", 32'(f_dti), 32'(rd(t_adr)));
        if (eg && !t_wre) chk("rnd_g_dti", 32'(g_dti), 32'(rd(t_adr)));
        if (eg && t_wre) mem[int'(t_adr)] = t_dto;
        if (ef) f_drop = 1'b1;
        if (eg) g_drop = 1'b1;
        if (owner != 0) begin
          if (w_ack) begin
            owner = 0; gap = 1;
          end
        end else if (gap != 0) begin
          gap = 0;
        end else if (f_stb || g_stb) begin
          if (f_stb && (!g_stb || last_g)) begin
            owner = 1; last_g = 1'b0; t_adr = f_adr; t_wre = 1'b0; t_dto = '0;
          end else begin
            owner = 2; last_g = 1'b1; t_adr = g_adr; t_wre = g_wre; t_dto = g_dto;
          end
          lat_t = $urandom_range(0, 3);
          lat_c = 0;
        end
        @(posedge clk);
        #1;
      end
      w_ack = 1'b0; f_stb = 1'b0; g_stb = 1'b0;
    end

`ifdef DCPU16_MBUS_TMO_EN
    // Watchdog: fetch never acknowledged completes on the 16th grant cycle.
    do_reset();
    f_stb = 1'b1; f_adr = 16'h0100;
    @(posedge clk); #1;
    for (int n = 1; n <= 16; n++) begin
      #1;
      chk($sformatf("tmo_f_ack%0d", n), 32'(f_ack), 32'(n == 16));
      if (n == 16) chk("tmo_f_dti", 32'(f_dti), 32'hFFFF);
      @(posedge clk); #1;
    end
    f_stb = 1'b0;
    chk("tmo_err_set", 32'(err), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("tmo_err_hold", 32'(err), 32'd1);
    do_reset();
    chk("tmo_err_clr", 32'(err), 32'd0);
`else
    chk("err_tied", 32'(err), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
